// File: rtl/id_stage.sv
// ARM pipeline instruction-decode stage: field decode, condition evaluation,
// 15-entry register file with write-through bypass, and the ID/EX register.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_in,
  input  logic [3:0]  status,
  input  logic        wb_wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [3:0]  src1_id,
  output logic [3:0]  src2_id,
  output logic        two_src,
  output logic        ex_wb_en,
  output logic        ex_mem_r_en,
  output logic        ex_mem_w_en,
  output logic        ex_b,
  output logic        ex_s,
  output logic [3:0]  ex_exe_cmd,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_val_rn,
  output logic [31:0] ex_val_rm,
  output logic        ex_imm,
  output logic [11:0] ex_shift_operand,
  output logic [23:0] ex_signed_imm_24,
  output logic [3:0]  ex_dest,
  output logic [3:0]  ex_src1,
  output logic [3:0]  ex_src2
);

  logic [3:0]  w_cond, w_opcode, w_rn, w_rd, w_rm;
  logic [1:0]  w_mode;
  logic        w_i, w_sbit, w_is_str, w_cond_ok, w_kill;
  logic        w_n, w_z, w_c, w_v;
  logic        w_wb, w_mr, w_mw, w_b, w_s;
  logic [3:0]  w_cmd;
  logic [31:0] w_val_rn, w_val_rm;
  logic [31:0] r_rf [0:14];

  assign w_cond   = instruction[31:28];
  assign w_mode   = instruction[27:26];
  assign w_i      = instruction[25];
  assign w_opcode = instruction[24:21];
  assign w_sbit   = instruction[20];
  assign w_rn     = instruction[19:16];
  assign w_rd     = instruction[15:12];
  assign w_rm     = instruction[3:0];
  assign {w_n, w_z, w_c, w_v} = status;

  assign w_is_str = (w_mode == 2'b01) && !w_sbit;
  assign src1_id  = w_rn;
  assign src2_id  = w_is_str ? w_rd : w_rm;
  assign two_src  = ~w_i | w_is_str;

  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = !w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = !w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = !w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = !w_v;
      4'b1000: w_cond_ok = w_c && !w_z;
      4'b1001: w_cond_ok = !w_c || w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = !w_z && (w_n == w_v);
      4'b1101: w_cond_ok = w_z || (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_kill = !w_cond_ok || hazard;

  always_comb begin
    w_wb  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_b   = 1'b0;
    w_s   = 1'b0;
    w_cmd = '0;
    case (w_mode)
      2'b00: begin
        w_wb = 1'b1;
        w_s  = w_sbit;
        case (w_opcode)
          4'b1101: w_cmd = 4'b0001;                   // MOV
          4'b1111: w_cmd = 4'b1001;                   // MVN
          4'b0100: w_cmd = 4'b0010;                   // ADD
          4'b0101: w_cmd = 4'b0011;                   // ADC
          4'b0010: w_cmd = 4'b0100;                   // SUB
          4'b0110: w_cmd = 4'b0101;                   // SBC
          4'b0000: w_cmd = 4'b0110;                   // AND
          4'b1100: w_cmd = 4'b0111;                   // ORR
          4'b0001: w_cmd = 4'b1000;                   // EOR
          4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; end  // CMP
          4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; end  // TST
          default: begin w_wb = 1'b0; w_s = 1'b0; end
        endcase
      end
      2'b01: begin
        w_cmd = 4'b0010;
        w_mr  = w_sbit;
        w_wb  = w_sbit;
        w_mw  = !w_sbit;
      end
      2'b10:   w_b = 1'b1;
      default: ;
    endcase
  end

  // R15 reads as pc_in; a same-cycle writeback to the read index wins over the array.
  always_comb begin
    w_val_rn = pc_in;
    if (src1_id != 4'd15)
      w_val_rn = (wb_wb_en && wb_dest == src1_id) ? wb_value : r_rf[src1_id];
  end

  always_comb begin
    w_val_rm = pc_in;
    if (src2_id != 4'd15)
      w_val_rm = (wb_wb_en && wb_dest == src2_id) ? wb_value : r_rf[src2_id];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 15; i++)
        r_rf[i] <= 32'(i);
    end else if (wb_wb_en && wb_dest != 4'd15) begin
      r_rf[wb_dest] <= wb_value;
    end
  end

  // Reset and an unfrozen flush share the all-zero load.
  always_ff @(posedge clk) begin
    if (!rst || (!freeze && flush)) begin
      ex_wb_en         <= 1'b0;
      ex_mem_r_en      <= 1'b0;
      ex_mem_w_en      <= 1'b0;
      ex_b             <= 1'b0;
      ex_s             <= 1'b0;
      ex_exe_cmd       <= '0;
      ex_pc            <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_imm           <= 1'b0;
      ex_shift_operand <= '0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_src1          <= '0;
      ex_src2          <= '0;
    end else if (!freeze) begin
      ex_wb_en         <= w_wb & ~w_kill;
      ex_mem_r_en      <= w_mr & ~w_kill;
      ex_mem_w_en      <= w_mw & ~w_kill;
      ex_b             <= w_b & ~w_kill;
      ex_s             <= w_s & ~w_kill;
      ex_exe_cmd       <= w_kill ? '0 : w_cmd;
      ex_pc            <= pc_in;
      ex_val_rn        <= w_val_rn;
      ex_val_rm        <= w_val_rm;
      ex_imm           <= w_i;
      ex_shift_operand <= instruction[11:0];
      ex_signed_imm_24 <= instruction[23:0];
      ex_dest          <= w_rd;
      ex_src1          <= w_rn;
      ex_src2          <= src2_id;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: an ARM-level decode model checked every cycle,
// plus literal expectations on hand-picked instructions.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, hazard;
  logic [31:0] instruction, pc_in;
  logic [3:0]  status;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  src1_id, src2_id;
  logic        two_src;
  logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
  logic [3:0]  ex_exe_cmd;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic        ex_imm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_signed_imm_24;
  logic [3:0]  ex_dest, ex_src1, ex_src2;

  int total = 0;
  int bad   = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
    .instruction(instruction), .pc_in(pc_in), .status(status),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .src1_id(src1_id), .src2_id(src2_id), .two_src(two_src),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc),
    .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm(ex_imm),
    .ex_shift_operand(ex_shift_operand), .ex_signed_imm_24(ex_signed_imm_24),
    .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] i24;
    logic [3:0]  dest, src1, src2;
  } ex_t;

  // ALU command per ARM data-processing opcode; -1 marks unsupported opcodes.
  int          dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
  logic [31:0] m_rf [15];
  ex_t         m;
  logic        mvalid = 1'b0;

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cf, v, base;
    {n, z, cf, v} = st;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic logic [31:0] rd(input logic [3:0] idx);
    if (idx == 4'd15) return pc_in;
    if (wb_wb_en && wb_dest == idx) return wb_value;
    return m_rf[idx];
  endfunction

  function automatic logic is_str(input logic [31:0] ins);
    return ins[27:26] == 2'b01 && !ins[20];
  endfunction

  function automatic ex_t predict();
    ex_t e;
    int  cmd;
    logic [3:0] s2;
    e  = '0;
    s2 = is_str(instruction) ? instruction[15:12] : instruction[3:0];
    case (instruction[27:26])
      2'b00: begin
        cmd = dp_cmd[instruction[24:21]];
        if (cmd >= 0) begin
          e.cmd = 4'(cmd);
          e.s   = instruction[20];
          e.wb  = !(instruction[24:21] inside {4'b1000, 4'b1010});
        end
      end
      2'b01: begin
        e.cmd = 4'b0010;
        e.mr  = instruction[20];
        e.wb  = instruction[20];
        e.mw  = !instruction[20];
      end
      2'b10:   e.b = 1'b1;
      default: ;
    endcase
    if (!cond_holds(instruction[31:28], status) || hazard) begin
      e.wb = 0; e.mr = 0; e.mw = 0; e.b = 0; e.s = 0; e.cmd = '0;
    end
    e.pc   = pc_in;
    e.rn   = rd(instruction[19:16]);
    e.rm   = rd(s2);
    e.imm  = instruction[25];
    e.sh   = instruction[11:0];
    e.i24  = instruction[23:0];
    e.dest = instruction[15:12];
    e.src1 = instruction[19:16];
    e.src2 = s2;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m = '0;
      for (int i = 0; i < 15; i++) m_rf[i] = 32'(i);
    end else begin
      if (!freeze) m = flush ? '0 : predict();
      if (wb_wb_en && wb_dest != 4'd15) m_rf[wb_dest] = wb_value;
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("wb_en",   32'(ex_wb_en),    32'(m.wb));
      chk("mem_r",   32'(ex_mem_r_en), 32'(m.mr));
      chk("mem_w",   32'(ex_mem_w_en), 32'(m.mw));
      chk("b",       32'(ex_b),        32'(m.b));
      chk("s",       32'(ex_s),        32'(m.s));
      chk("cmd",     32'(ex_exe_cmd),  32'(m.cmd));
      chk("pc",      ex_pc,            m.pc);
      chk("val_rn",  ex_val_rn,        m.rn);
      chk("val_rm",  ex_val_rm,        m.rm);
      chk("imm",     32'(ex_imm),      32'(m.imm));
      chk("shift",   32'(ex_shift_operand), 32'(m.sh));
      chk("imm24",   32'(ex_signed_imm_24), 32'(m.i24));
      chk("dest",    32'(ex_dest),     32'(m.dest));
      chk("src1",    32'(ex_src1),     32'(m.src1));
      chk("src2",    32'(ex_src2),     32'(m.src2));
      chk("src1_id", 32'(src1_id),     32'(instruction[19:16]));
      chk("src2_id", 32'(src2_id),
          32'(is_str(instruction) ? instruction[15:12] : instruction[3:0]));
      chk("two_src", 32'(two_src),     32'(!instruction[25] || is_str(instruction)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; freeze = 0; flush = 0; hazard = 0;
    instruction = '0; pc_in = '0; status = '0;
    wb_wb_en = 0; wb_dest = '0; wb_value = '0;
    tick(); tick();
    chk("L_rst_wb",  32'(ex_wb_en), 32'd0);
    chk("L_rst_pc",  ex_pc,         32'd0);
    chk("L_rst_rn",  ex_val_rn,     32'd0);

    rst = 1; instruction = 32'hE0851003; pc_in = 32'h4;
    tick();
    chk("L_r5", ex_val_rn, 32'd5);

    instruction = 32'hE0821003; pc_in = 32'h8;
    #1 chk("L_add_two", 32'(two_src), 32'd1);
    tick();
    chk("L_add_cmd",  32'(ex_exe_cmd), 32'h2);
    chk("L_add_wb",   32'(ex_wb_en),   32'd1);
    chk("L_add_rn",   ex_val_rn,       32'd2);
    chk("L_add_rm",   ex_val_rm,       32'd3);
    chk("L_add_dest", 32'(ex_dest),    32'd1);
    chk("L_add_pc",   ex_pc,           32'h8);

    instruction = 32'h00821003; status = 4'b0000;
    tick();
    chk("L_eq_wb",   32'(ex_wb_en),   32'd0);
    chk("L_eq_cmd",  32'(ex_exe_cmd), 32'd0);
    chk("L_eq_dest", 32'(ex_dest),    32'd1);
    status = 4'b0100;
    tick();
    chk("L_eq_z_wb", 32'(ex_wb_en), 32'd1);
    status = 4'b0000;

    instruction = 32'hE5854000;
    #1;
    chk("L_str_src2", 32'(src2_id), 32'd4);
    chk("L_str_two",  32'(two_src), 32'd1);
    tick();
    chk("L_str_mw",  32'(ex_mem_w_en), 32'd1);
    chk("L_str_wb",  32'(ex_wb_en),    32'd0);
    chk("L_str_cmd", 32'(ex_exe_cmd),  32'h2);
    chk("L_str_rm",  ex_val_rm,        32'd4);

    instruction = 32'hE5954000;
    tick();
    chk("L_ldr_mr", 32'(ex_mem_r_en), 32'd1);
    chk("L_ldr_wb", 32'(ex_wb_en),    32'd1);

    instruction = 32'hE0821003; pc_in = 32'h8;
    wb_wb_en = 1; wb_dest = 4'd2; wb_value = 32'hDEADBEEF;
    tick();
    chk("L_bypass", ex_val_rn, 32'hDEADBEEF);

    wb_dest = 4'd15; wb_value = 32'h12345678;
    instruction = 32'hE08F1003; pc_in = 32'h40;
    tick();
    chk("L_r15_pc", ex_val_rn, 32'h40);
    wb_wb_en = 0;
    for (int r = 0; r < 15; r++) begin
      instruction = 32'hE0800000 | (32'(r) << 16) | 32'(r);
      tick();
      chk("L_rf_scan", ex_val_rn, (r == 2) ? 32'hDEADBEEF : 32'(r));
    end

    instruction = 32'hE0821003; pc_in = 32'h8; hazard = 1;
    tick();
    chk("L_haz_wb",   32'(ex_wb_en),   32'd0);
    chk("L_haz_cmd",  32'(ex_exe_cmd), 32'd0);
    chk("L_haz_dest", 32'(ex_dest),    32'd1);
    chk("L_haz_pc",   ex_pc,           32'h8);
    hazard = 0;

    instruction = 32'hEA000010;
    tick();
    chk("L_b",     32'(ex_b),             32'd1);
    chk("L_b_i24", 32'(ex_signed_imm_24), 32'h10);

    for (int op = 0; op < 16; op++)
      for (int s = 0; s < 2; s++) begin
        instruction = 32'hE2021003 | (32'(op) << 21) | (32'(s) << 20);
        tick();
      end
    for (int c = 0; c < 16; c++) begin
      instruction = (32'(c) << 28) | 32'h00921003;
      status = 4'(c); tick();
      status = ~4'(c); tick();
    end
    status = 4'b0000;

    instruction = 32'hE0821003; pc_in = 32'h8;
    tick();
    freeze = 1; flush = 1; instruction = 32'hE3A00005; pc_in = 32'h20;
    wb_wb_en = 1; wb_dest = 4'd7; wb_value = 32'h77;
    tick();
    wb_wb_en = 0;
    tick();
    chk("L_frz_pc",  ex_pc,           32'h8);
    chk("L_frz_cmd", 32'(ex_exe_cmd), 32'h2);
    freeze = 0;
    tick();
    chk("L_fl_wb",  32'(ex_wb_en),   32'd0);
    chk("L_fl_cmd", 32'(ex_exe_cmd), 32'd0);
    chk("L_fl_pc",  ex_pc,           32'd0);
    hazard = 1; instruction = 32'hE0821003; pc_in = 32'h8;
    tick();
    chk("L_flhz_pc", ex_pc, 32'd0);
    flush = 0; hazard = 0;

    instruction = 32'hE0871003;
    tick();
    chk("L_frz_wr", ex_val_rn, 32'h77);

    instruction = 32'hE0821003;
    tick();
    rst = 0; freeze = 1; wb_wb_en = 1; wb_dest = 4'd3; wb_value = 32'h99;
    tick();
    chk("L_mrst_wb", 32'(ex_wb_en), 32'd0);
    chk("L_mrst_pc", ex_pc,         32'd0);
    rst = 1; freeze = 0; wb_wb_en = 0;
    tick();
    chk("L_post_rn", ex_val_rn,     32'd2);
    chk("L_post_rm", ex_val_rm,     32'd3);
    chk("L_post_wb", 32'(ex_wb_en), 32'd1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage ARM pipeline, directly downstream of instruction fetch. It consumes the fetched instruction and its PC+4 and decodes opcode, mode and condition into control signals. It holds the 15-entry general register file, written back from WB, and latches everything into the ID/EX pipeline register that feeds the execute stage. It also exposes the combinational source-register indices the hazard unit needs.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 15 GPRs R0–R14)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- freeze  in  1  memory stall; hold ID/EX register and suppress nothing else
- flush  in  1  branch taken in EX; load bubble into ID/EX
- hazard  in  1  data hazard from hazard unit; zero control into ID/EX
- instruction  in  32  instruction from IF/ID
- pc_in  in  32  PC+4 from IF/ID
- status  in  4  NZCV from status register (N=bit3 … V=bit0)
- wb_wb_en  in  1  writeback enable
- wb_dest  in  4  writeback register index
- wb_value  in  32  writeback data
- src1_id, src2_id  out  4  combinational Rn, and Rm or Rd, for the hazard unit
- two_src  out  1  combinational; instruction reads a second register
- ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s  out  1 each  registered controls
- ex_exe_cmd  out  4  registered ALU command
- ex_pc  out  32  registered pc_in
- ex_val_rn, ex_val_rm  out  32  registered operand values
- ex_imm  out  1  registered I bit
- ex_shift_operand  out  12  registered instruction[11:0]
- ex_signed_imm_24  out  24  registered instruction[23:0]
- ex_dest, ex_src1, ex_src2  out  4  registered Rd, Rn, second source

## Operation
- Fields: cond[31:28], I[25], mode[27:26], opcode[24:21], S[20], Rn[19:16], Rd[15:12], Rm[3:0].
- Decode by mode:
  - mode 00, data processing: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 0100, TST 0110. wb_en is set except for CMP and TST. Unlisted opcodes give all controls 0.
  - mode 01, memory: exe_cmd 0010. S=1 gives LDR (mem_r_en, wb_en). S=0 gives STR (mem_w_en).
  - mode 10: b=1, no wb_en.
- s is the S bit for mode 00, 0 otherwise.
- Condition codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL (1110) evaluated against status; 1111 counts as fail.
- On condition fail or hazard=1, wb_en, mem_r_en, mem_w_en, b, s and exe_cmd are forced to 0 before latching. Data fields still latch.
- src2_id = Rd when the instruction is STR, else Rm. two_src = ~I | STR. Both are combinational from instruction.
- Register file: 15×32, R15 unimplemented.
  - Reading index 15 returns pc_in.
  - Write on rising edge when wb_wb_en=1 and wb_dest≠15. Writes to index 15 are ignored.
  - Read-during-write bypass: if wb_wb_en and wb_dest equals the read index (≠15), the read returns wb_value in the same cycle.

## Timing
- Latency: instruction to ex_* is one cycle.
- Reset (rst=0 at an edge):
  - Every ex_* output goes to 0.
  - Register file Ri resets to i (R0=0 … R14=14).
  - Reset overrides freeze, flush and writeback.
- Edge priority: rst > freeze (ID/EX holds all values) > flush (ID/EX loads all zeros) > normal load.
- Freeze does not block register-file writeback.
- Flush and hazard together behave as flush.
- Reset asserted mid-stream discards the in-flight ID/EX contents. The first post-reset edge with rst=1 loads normally.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release. Required: all ex_* = 0; reading Rn=5 gives ex_val_rn=5 after the first load.
- ADD R1,R2,R3 (0xE0821003), status=0, pc_in=0x8. Required next cycle: exe_cmd=0010, wb_en=1, val_rn=2, val_rm=3, dest=1, ex_pc=0x8, two_src=1.
- Condition fail: ADDEQ (0x00821003) with Z=0. Required: all controls 0 and dest=1. Repeat with status=0100: wb_en=1.
- STR R4,[R5] (0xE5854000). Required: src2_id=4, two_src=1, mem_w_en=1, wb_en=0, exe_cmd=0010.
- Bypass: wb_wb_en=1, wb_dest=2, wb_value=0xDEADBEEF in the same cycle as decoding the ADD above. Required: ex_val_rn=0xDEADBEEF. Also write to wb_dest=15 and confirm no register changes.
- Freeze/flush: decode ADD, then freeze=1 and flush=1 for 2 cycles with a new instruction. Required: ex_* unchanged. Then freeze=0 with flush=1. Required: controls 0 and ex_pc=0.
